// File: rtl/group_acc_pkg.sv
// Shared result record and width-generic arithmetic helpers for the group accumulator.
// Helpers operate on a 64-bit carrier with the real operand width passed in.
package group_acc_pkg;

    localparam int MAX_W         = 64;
    localparam int DEF_OUT_WIDTH = 40;
    localparam int DEF_CH_W      = 2;
    localparam int DEF_CNT_W     = 8;

    typedef logic [MAX_W-1:0] wide_t;

    typedef struct packed {
        logic [DEF_OUT_WIDTH-1:0] sum;
        logic [DEF_CH_W-1:0]      channel;
        logic [DEF_CNT_W-1:0]     count;
        logic                     overflow;
    } result_t;

    function automatic wide_t width_mask(input int w);
        return (w >= MAX_W) ? '1 : ((wide_t'(1) << w) - wide_t'(1));
    endfunction

    // Sign- or zero-extend the low w bits of v across the whole carrier.
    function automatic wide_t ext_operand(input wide_t v, input int w, input logic sgn);
        logic neg;
        neg = sgn && (((v >> (w - 1)) & wide_t'(1)) != '0);
        return neg ? (v | ~width_mask(w)) : (v & width_mask(w));
    endfunction

    // Operands are already extended, so bit w of the sum is the (w+1)-bit result's top bit.
    function automatic logic add_overflows(input wide_t a, input wide_t b, input int w,
                                           input logic sgn);
        wide_t s;
        logic  hi;
        logic  msb;
        s   = a + b;
        hi  = ((s >> w) & wide_t'(1)) != '0;
        msb = ((s >> (w - 1)) & wide_t'(1)) != '0;
        return sgn ? (hi != msb) : hi;
    endfunction

    function automatic wide_t sat_add(input wide_t a, input wide_t b, input int w,
                                      input logic sgn, input logic sat);
        wide_t s;
        s = a + b;
        if (sat && add_overflows(a, b, w, sgn)) begin
            if (!sgn)
                s = width_mask(w);
            else if (((s >> w) & wide_t'(1)) != '0)
                s = wide_t'(1) << (w - 1);
            else
                s = width_mask(w) >> 1;
        end
        return s & width_mask(w);
    endfunction

endpackage

// File: rtl/group_acc_obuf.sv
// Result FIFO between the accumulator and the consumer; head is visible whenever non-empty.
// Occupancy, full and empty are registered so ready has no path from the pop side.
module group_acc_obuf
    import group_acc_pkg::*;
#(
    parameter type data_t = result_t,
    parameter int  DEPTH  = 8
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  data_t data_i,
    input  logic  pop_i,
    output data_t data_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int AW = $clog2(DEPTH);

    data_t         mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic          do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == (AW + 1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    assign data_o  = empty_q ? '0 : mem[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/multichannel_group_accumulator.sv
// Per-channel running sums over interleaved groups; each completed group is queued
// as {sum, channel, count, overflow} in an output FIFO.
module multichannel_group_accumulator
    import group_acc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int OUT_WIDTH  = 40,
    parameter int CHANNELS   = 4,
    parameter int OBUF_DEPTH = 8,
    parameter int MAX_GROUP  = 255,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 1,
    localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W     = $clog2(MAX_GROUP + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    output logic                 ready,
    input  logic [WIDTH-1:0]     in,
    input  logic [CH_W-1:0]      in_channel,
    input  logic                 end_of_group,
    output logic                 valid_out,
    input  logic                 hold_output,
    output logic [OUT_WIDTH-1:0] out,
    output logic [CH_W-1:0]      out_channel,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_overflow
);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] sum;
        logic [CH_W-1:0]      channel;
        logic [CNT_W-1:0]     count;
        logic                 overflow;
    } res_t;

    logic [OUT_WIDTH-1:0] acc_arr [CHANNELS];
    logic [CNT_W-1:0]     cnt_arr [CHANNELS];
    logic                 ovf_arr [CHANNELS];

    logic [CH_W-1:0]      ch_sel;
    wide_t                acc_ext, in_ext;
    logic [OUT_WIDTH-1:0] sum_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 ovf_d;
    logic                 accept, push, pop, full, empty;
    res_t                 push_res, head_res;

    assign ch_sel = (CHANNELS > 1) ? in_channel : '0;
    assign ready  = rst && !full;
    assign accept = valid_in && ready;
    assign push   = accept && end_of_group;
    assign pop    = valid_out && !hold_output;

    assign acc_ext = ext_operand(wide_t'(acc_arr[ch_sel]), OUT_WIDTH, SIGNED != 0);
    assign in_ext  = ext_operand(wide_t'(in), WIDTH, SIGNED != 0);
    assign sum_d   = OUT_WIDTH'(sat_add(acc_ext, in_ext, OUT_WIDTH, SIGNED != 0, SATURATE != 0));
    assign ovf_d   = ovf_arr[ch_sel] || add_overflows(acc_ext, in_ext, OUT_WIDTH, SIGNED != 0);
    assign cnt_d   = (cnt_arr[ch_sel] == CNT_W'(MAX_GROUP)) ? cnt_arr[ch_sel]
                                                            : cnt_arr[ch_sel] + 1'b1;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [OUT_WIDTH-1:0] acc_q;
            logic [CNT_W-1:0]     cnt_q;
            logic                 ovf_q;
            logic                 hit;

            assign hit = accept && (ch_sel == CH_W'(gi));

            // A final beat leaves the channel clean for its next group.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    acc_q <= '0;
                    cnt_q <= '0;
                    ovf_q <= 1'b0;
                end else if (hit) begin
                    acc_q <= end_of_group ? '0 : sum_d;
                    cnt_q <= end_of_group ? '0 : cnt_d;
                    ovf_q <= end_of_group ? 1'b0 : ovf_d;
                end
            end

            assign acc_arr[gi] = acc_q;
            assign cnt_arr[gi] = cnt_q;
            assign ovf_arr[gi] = ovf_q;
        end
    endgenerate

    always_comb begin
        push_res          = '0;
        push_res.sum      = sum_d;
        push_res.channel  = ch_sel;
        push_res.count    = cnt_d;
        push_res.overflow = ovf_d;
    end

    group_acc_obuf #(
        .data_t (res_t),
        .DEPTH  (OBUF_DEPTH)
    ) u_obuf (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .data_i  (push_res),
        .pop_i   (pop),
        .data_o  (head_res),
        .full_o  (full),
        .empty_o (empty)
    );

    assign valid_out    = !empty;
    assign out          = head_res.sum;
    assign out_channel  = head_res.channel;
    assign out_count    = head_res.count;
    assign out_overflow = head_res.overflow;

endmodule

// File: tb/tb_multichannel_group_accumulator.sv
// Directed and scoreboarded stimulus for the group accumulator, plus two narrow signed
// instances exercising saturating versus wrapping overflow.
module tb_multichannel_group_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready;
    logic [31:0] in_data = '0;
    logic [1:0]  in_ch = '0;
    logic        eog = 1'b0;
    logic        valid_out;
    logic        hold_output = 1'b0;
    logic [39:0] out_data;
    logic [1:0]  out_ch;
    logic [7:0]  out_cnt;
    logic        out_ovf;

    logic        s_valid = 1'b0;
    logic [7:0]  s_in = '0;
    logic        s_eog = 1'b0;
    logic        s_hold = 1'b0;
    logic        s_ch = 1'b0;
    logic        sat_ready, sat_vout, sat_och, sat_ovf;
    logic [7:0]  sat_out, sat_cnt;
    logic        wrp_ready, wrp_vout, wrp_och, wrp_ovf;
    logic [7:0]  wrp_out, wrp_cnt;

    int n_checks = 0;
    int n_errors = 0;
    bit rand_hold = 1'b0;

    typedef struct {
        longint unsigned sum;
        int              ch;
        int              cnt;
        bit              ovf;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    multichannel_group_accumulator u_dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready(ready), .in(in_data),
        .in_channel(in_ch), .end_of_group(eog), .valid_out(valid_out),
        .hold_output(hold_output), .out(out_data), .out_channel(out_ch),
        .out_count(out_cnt), .out_overflow(out_ovf)
    );

    multichannel_group_accumulator #(
        .WIDTH(8), .OUT_WIDTH(8), .CHANNELS(1), .OBUF_DEPTH(2), .SIGNED(1), .SATURATE(1)
    ) u_sat (
        .clk(clk), .rst(rst), .valid_in(s_valid), .ready(sat_ready), .in(s_in),
        .in_channel(s_ch), .end_of_group(s_eog), .valid_out(sat_vout),
        .hold_output(s_hold), .out(sat_out), .out_channel(sat_och),
        .out_count(sat_cnt), .out_overflow(sat_ovf)
    );

    multichannel_group_accumulator #(
        .WIDTH(8), .OUT_WIDTH(8), .CHANNELS(1), .OBUF_DEPTH(2), .SIGNED(1), .SATURATE(0)
    ) u_wrap (
        .clk(clk), .rst(rst), .valid_in(s_valid), .ready(wrp_ready), .in(s_in),
        .in_channel(s_ch), .end_of_group(s_eog), .valid_out(wrp_vout),
        .hold_output(s_hold), .out(wrp_out), .out_channel(wrp_och),
        .out_count(wrp_cnt), .out_overflow(wrp_ovf)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic expect_res(input longint unsigned sum, input int ch, input int cnt,
                              input bit ovf);
        exp_t e;
        e.sum = sum; e.ch = ch; e.cnt = cnt; e.ovf = ovf;
        exp_q.push_back(e);
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1 of the accepting edge.
    task automatic send_beat(input int ch, input logic [31:0] v, input bit last,
                             output bit accepted);
        int waited = 0;
        valid_in = 1'b1; in_ch = 2'(ch); in_data = v; eog = last;
        @(negedge clk);
        while (!ready && waited < 400) begin
            waited++;
            @(negedge clk);
        end
        accepted = ready;
        if (!ready) check("accept_timeout", 64'(ready), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0; eog = 1'b0;
        $display("beat ch=%0d val=%0d eog=%0d accepted=%0d", ch, v, last, accepted);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (rst && valid_out && !hold_output) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(valid_out), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("result ch=%0d sum=%0d cnt=%0d ovf=%0d", out_ch, out_data, out_cnt,
                         out_ovf);
                check("res_sum", 64'(out_data), 64'(e.sum));
                check("res_ch", 64'(out_ch), 64'(e.ch));
                check("res_cnt", 64'(out_cnt), 64'(e.cnt));
                check("res_ovf", 64'(out_ovf), 64'(e.ovf));
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_hold) hold_output = ($urandom_range(0, 3) != 0);
    end

    initial begin
        bit              ok;
        longint unsigned acc[4];
        int              cnt[4];
        int              ch;
        logic [31:0]     v;
        bit              last;

        // Reset state
        #12;
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_out", 64'(out_data), 64'd0);
        check("rst_count", 64'(out_cnt), 64'd0);
        #4 rst = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 64'(ready), 64'd1);

        // T1: single group on channel 0, one-cycle latency
        send_beat(0, 3, 0, ok);
        send_beat(0, 4, 0, ok);
        check("t1_no_early_valid", 64'(valid_out), 64'd0);
        send_beat(0, 5, 1, ok);
        expect_res(12, 0, 3, 0);
        check("t1_latency", 64'(valid_out), 64'd1);
        check("t1_sum", 64'(out_data), 64'd12);
        check("t1_count", 64'(out_cnt), 64'd3);
        wait_drain("t1_drain");

        // T2: interleaved channels complete in completion order
        send_beat(0, 1, 0, ok);
        send_beat(1, 10, 0, ok);
        send_beat(0, 2, 1, ok);  expect_res(3, 0, 2, 0);
        send_beat(1, 20, 0, ok);
        send_beat(1, 30, 1, ok); expect_res(60, 1, 3, 0);
        wait_drain("t2_drain");

        // Count saturates at 255 for a 300-beat group
        for (int i = 0; i < 299; i++) send_beat(3, 1, 0, ok);
        send_beat(3, 1, 1, ok);
        expect_res(300, 3, 255, 0);
        wait_drain("cnt_sat_drain");

        // T3: fill the buffer under hold, then release
        hold_output = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(1, 100 + i, 1, ok);
            expect_res(longint'(100 + i), 1, 1, 0);
        end
        check("t3_full_ready", 64'(ready), 64'd0);
        check("t3_head", 64'(out_data), 64'd100);
        fork
            begin
                send_beat(2, 200, 1, ok); expect_res(200, 2, 1, 0);
                send_beat(2, 201, 1, ok); expect_res(201, 2, 1, 0);
            end
            begin
                repeat (3) @(posedge clk);
                #2;
                check("t3_still_full", 64'(ready), 64'd0);
                check("t3_head_held", 64'(out_data), 64'd100);
                hold_output = 1'b0;
                #1;
                check("t3_no_comb_ready", 64'(ready), 64'd0);
            end
        join
        wait_drain("t3_drain");

        // T4: signed 8-bit overflow, saturating vs wrapping builds
        @(posedge clk); #1;
        s_valid = 1'b1; s_in = 8'd100; s_eog = 1'b0;
        @(posedge clk); #1;
        check("t4_no_early", 64'(sat_vout), 64'd0);
        s_eog = 1'b1;
        @(posedge clk); #1;
        s_valid = 1'b0; s_eog = 1'b0;
        check("t4_sat_valid", 64'(sat_vout), 64'd1);
        check("t4_sat_sum", 64'(sat_out), 64'h7f);
        check("t4_sat_ovf", 64'(sat_ovf), 64'd1);
        check("t4_sat_cnt", 64'(sat_cnt), 64'd2);
        check("t4_wrap_sum", 64'(wrp_out), 64'hc8);
        check("t4_wrap_ovf", 64'(wrp_ovf), 64'd1);

        // T5: reset mid-group with results buffered
        hold_output = 1'b1;
        send_beat(0, 11, 1, ok);
        send_beat(3, 22, 1, ok);
        send_beat(2, 5, 0, ok);
        #2 rst = 1'b0;
        #1;
        check("t5_valid_out", 64'(valid_out), 64'd0);
        check("t5_ready", 64'(ready), 64'd0);
        check("t5_out", 64'(out_data), 64'd0);
        exp_q.delete();
        @(posedge clk); #2;
        rst = 1'b1;
        hold_output = 1'b0;
        @(posedge clk); #1;
        send_beat(2, 7, 1, ok);
        expect_res(7, 2, 1, 0);
        check("t5_valid_after", 64'(valid_out), 64'd1);
        wait_drain("t5_drain");

        // T6: random interleaved traffic against a reference model
        for (int c = 0; c < 4; c++) begin acc[c] = 0; cnt[c] = 0; end
        rand_hold = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            ch   = $urandom_range(0, 3);
            v    = $urandom;
            last = ($urandom_range(0, 3) == 0);
            send_beat(ch, v, last, ok);
            if (ok) begin
                acc[ch] += longint'(v);
                cnt[ch] = (cnt[ch] == 255) ? 255 : cnt[ch] + 1;
                if (last) begin
                    expect_res(acc[ch], ch, cnt[ch], 0);
                    acc[ch] = 0;
                    cnt[ch] = 0;
                end
            end
        end
        rand_hold = 1'b0;
        @(posedge clk); #2;
        hold_output = 1'b0;
        wait_drain("t6_drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
